// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT sequencers: FSM state encoding and
// butterfly address arithmetic for in-place decimation-in-frequency stages.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

  // Distance between the two legs of a butterfly in stage s.
  function automatic int unsigned bf_span(input int unsigned n_log2, input int unsigned s);
    return 32'd1 << (n_log2 - 32'd1 - s);
  endfunction

  function automatic int unsigned bf_off(input int unsigned span, input int unsigned k);
    return k & (span - 32'd1);
  endfunction

  function automatic int unsigned bf_grp(input int unsigned n_log2, input int unsigned s,
                                         input int unsigned k);
    return k >> (n_log2 - 32'd1 - s);
  endfunction

  function automatic int unsigned bf_addr_a(input int unsigned n_log2, input int unsigned s,
                                            input int unsigned k);
    int unsigned span;
    span = bf_span(n_log2, s);
    return ((bf_grp(n_log2, s, k) * span) << 1) + bf_off(span, k);
  endfunction

  function automatic int unsigned bf_tw(input int unsigned n_log2, input int unsigned s,
                                        input int unsigned k);
    return bf_off(bf_span(n_log2, s), k) << s;
  endfunction

endpackage

// File: rtl/but_stage_seq_if.sv
// Control/address bundle between the FFT controller, sample RAM and twiddle ROM
// on one side and the stage sequencer on the other.
interface but_stage_seq_if #(
  parameter int N_LOG2 = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic [N_LOG2-1:0] stage;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [N_LOG2-2:0] tw_addr;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/but_addr_dly.sv
// Delays the read strobe and pair addresses by the RAM read latency so the
// write-back lands on the same pair the butterfly is currently computing.
module but_addr_dly #(
  parameter int AW    = 4,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          en_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o
);
  localparam int W = 2 * AW + 1;

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {en_i, addr_a_i, addr_b_i};
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {en_o, addr_a_o, addr_b_o} = pipe_q[DEPTH-1];
endmodule

// File: rtl/but_stage_seq.sv
// In-place radix-2 DIF stage sequencer: walks every butterfly pair of every
// stage, then replays the pair addresses as write-backs after the read latency.
module but_stage_seq
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 4,
  parameter int RD_LAT = 1,
  parameter int AW     = N_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  but_stage_seq_if.master       seq_if
);
  localparam int K_W  = N_LOG2 - 1;
  localparam int TW_W = N_LOG2 - 1;
  localparam logic [K_W-1:0]    K_LAST    = '1;
  localparam logic [N_LOG2-1:0] S_LAST    = N_LOG2'(N_LOG2 - 1);
  localparam logic [1:0]        DCNT_LAST = 2'(RD_LAT - 1);

  seq_state_e        state_q, state_d;
  logic [N_LOG2-1:0] s_q, s_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]     rd_addr_b_q, rd_addr_b_d;
  logic [TW_W-1:0]   tw_addr_q, tw_addr_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seq_if.start) begin
          state_d = ST_RUN;
          s_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d     = k_q + K_W'(1);
          rd_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Reads pause until the last write of this stage has landed.
        if (dcnt_q == DCNT_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + N_LOG2'(1);
            k_d     = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses are derived from the next pair so they appear with rd_en.
  always_comb begin
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_addr_d   = tw_addr_q;
    if (rd_en_d) begin
      rd_addr_a_d = AW'(bf_addr_a(N_LOG2, 32'(s_d), 32'(k_d)));
      rd_addr_b_d = rd_addr_a_d + AW'(bf_span(N_LOG2, 32'(s_d)));
      tw_addr_d   = TW_W'(bf_tw(N_LOG2, 32'(s_d), 32'(k_d)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
    end
  end

  but_addr_dly #(
    .AW    (AW),
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (rd_en_q),
    .addr_a_i (rd_addr_a_q),
    .addr_b_i (rd_addr_b_q),
    .en_o     (seq_if.wr_en),
    .addr_a_o (seq_if.wr_addr_a),
    .addr_b_o (seq_if.wr_addr_b)
  );

  assign seq_if.busy      = busy_q;
  assign seq_if.done      = done_q;
  assign seq_if.stage     = s_q;
  assign seq_if.rd_en     = rd_en_q;
  assign seq_if.rd_addr_a = rd_addr_a_q;
  assign seq_if.rd_addr_b = rd_addr_b_q;
  assign seq_if.tw_addr   = tw_addr_q;
endmodule

// File: tb/tb_but_stage_seq.sv
// Bench for but_stage_seq: cycle-exact trace against a stage/block model, spec
// pair tables, start/reset corner cases and a number-theoretic FFT golden run.
module tb_but_stage_seq;
  localparam int NL = 4;
  localparam int N  = 16;
  localparam int H  = 8;
  localparam int P  = 257;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  but_stage_seq_if #(.N_LOG2(NL)) if1 ();
  but_stage_seq_if #(.N_LOG2(NL)) if3 ();

  but_stage_seq #(.N_LOG2(NL), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .seq_if(if1));
  but_stage_seq #(.N_LOG2(NL), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .seq_if(if3));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } pair_vec_t;
  pair_vec_t tbl[$];

  // RAM + butterfly model over GF(257); 2 is a primitive 16th root of unity.
  int unsigned mem[N];
  int unsigned init_mem[N];
  int unsigned wpow[N];
  bit          load_req = 1'b0;
  int unsigned rda_q = 0, rdb_q = 0, tw_q = 0;

  always @(posedge clk) begin
    if (load_req) begin
      mem <= init_mem;
    end else begin
      if (if1.wr_en === 1'b1) begin
        mem[if1.wr_addr_a] <= (rda_q + rdb_q) % P;
        mem[if1.wr_addr_b] <= (((rda_q + P - rdb_q) % P) * wpow[tw_q]) % P;
      end
      if (if1.rd_en === 1'b1) begin
        rda_q <= mem[if1.rd_addr_a];
        rdb_q <= mem[if1.rd_addr_b];
        tw_q  <= 32'(if1.tw_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input bit sel3, input logic v);
    if (sel3) if3.start = v;
    else      if1.start = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},  32'(if1.busy),  0);
    chk({tag, " done"},  32'(if1.done),  0);
    chk({tag, " stage"}, 32'(if1.stage), 0);
    chk({tag, " rd_en"}, 32'(if1.rd_en), 0);
    chk({tag, " rd_a"},  32'(if1.rd_addr_a), 0);
    chk({tag, " rd_b"},  32'(if1.rd_addr_b), 0);
    chk({tag, " tw"},    32'(if1.tw_addr), 0);
    chk({tag, " wr_en"}, 32'(if1.wr_en), 0);
    chk({tag, " wr_a"},  32'(if1.wr_addr_a), 0);
    chk({tag, " wr_b"},  32'(if1.wr_addr_b), 0);
    chk({tag, " busy3"}, 32'(if3.busy), 0);
    chk({tag, " rd_en3"}, 32'(if3.rd_en), 0);
  endtask

  // Must be called at a falling edge; start is raised there (cycle 0).
  task automatic run_check(input bit sel3, input bit poke);
    int rl;
    int tt;
    int c;
    bit exp_rd[128];
    bit exp_wr[128];
    int ea[128], eb[128], et[128], es[128], wa[128], wb[128];
    logic ra, rw, bz, dn;
    logic [3:0] g_ra, g_rb, g_wa, g_wb, g_st;
    logic [2:0] g_tw;
    rl = sel3 ? 3 : 1;
    tt = NL * (H + rl);
    for (int i = 0; i < 128; i++) begin
      exp_rd[i] = 0; exp_wr[i] = 0;
      ea[i] = 0; eb[i] = 0; et[i] = 0; es[i] = 0; wa[i] = 0; wb[i] = 0;
    end
    c = 1;
    for (int s = 0; s < NL; s++) begin
      int span;
      span = N >> (s + 1);
      for (int blk = 0; blk < N; blk += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          exp_rd[c] = 1; ea[c] = blk + j; eb[c] = blk + j + span;
          et[c] = j << s; es[c] = s; c++;
        end
      end
      for (int d = 0; d < rl; d++) begin
        es[c] = s; c++;
      end
    end
    for (int i = 1; i <= tt; i++) begin
      if (exp_rd[i]) begin
        exp_wr[i + rl] = 1; wa[i + rl] = ea[i]; wb[i + rl] = eb[i];
      end
    end

    set_start(sel3, 1'b1);
    for (int i = 1; i <= tt + 2; i++) begin
      @(negedge clk);
      set_start(sel3, poke && (i == 5 || i == 20 || i == tt + 1));
      ra   = sel3 ? if3.rd_en     : if1.rd_en;
      rw   = sel3 ? if3.wr_en     : if1.wr_en;
      bz   = sel3 ? if3.busy      : if1.busy;
      dn   = sel3 ? if3.done      : if1.done;
      g_st = sel3 ? if3.stage     : if1.stage;
      g_ra = sel3 ? if3.rd_addr_a : if1.rd_addr_a;
      g_rb = sel3 ? if3.rd_addr_b : if1.rd_addr_b;
      g_tw = sel3 ? if3.tw_addr   : if1.tw_addr;
      g_wa = sel3 ? if3.wr_addr_a : if1.wr_addr_a;
      g_wb = sel3 ? if3.wr_addr_b : if1.wr_addr_b;
      chk($sformatf("L%0d c%0d busy", rl, i),  32'(bz), 32'(i <= tt));
      chk($sformatf("L%0d c%0d done", rl, i),  32'(dn), 32'(i == tt + 1));
      chk($sformatf("L%0d c%0d rd_en", rl, i), 32'(ra), 32'(exp_rd[i]));
      chk($sformatf("L%0d c%0d wr_en", rl, i), 32'(rw), 32'(exp_wr[i]));
      if (i <= tt)     chk($sformatf("L%0d c%0d stage", rl, i), 32'(g_st), es[i]);
      if (i == tt + 2) chk($sformatf("L%0d c%0d stage idle", rl, i), 32'(g_st), 0);
      if (exp_rd[i]) begin
        chk($sformatf("L%0d c%0d rd_a", rl, i), 32'(g_ra), ea[i]);
        chk($sformatf("L%0d c%0d rd_b", rl, i), 32'(g_rb), eb[i]);
        chk($sformatf("L%0d c%0d tw", rl, i),   32'(g_tw), et[i]);
      end
      if (exp_wr[i]) begin
        chk($sformatf("L%0d c%0d wr_a", rl, i), 32'(g_wa), wa[i]);
        chk($sformatf("L%0d c%0d wr_b", rl, i), 32'(g_wb), wb[i]);
      end
      if (!sel3) begin
        foreach (tbl[e]) begin
          if (tbl[e].cyc == i) begin
            chk($sformatf("tbl c%0d pair_a", i), 32'(g_ra), tbl[e].a);
            chk($sformatf("tbl c%0d pair_b", i), 32'(g_rb), tbl[e].b);
            chk($sformatf("tbl c%0d tw", i),     32'(g_tw), tbl[e].tw);
          end
        end
      end
    end
    $display("run RD_LAT=%0d poke=%0d checked %0d cycles, total=%0d bad=%0d", rl, poke, tt + 2, total, bad);
  endtask

  function automatic int bitrev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < NL; b++) r = (r << 1) | ((k >> b) & 1);
    return r;
  endfunction

  initial begin
    int unsigned p;
    int unsigned acc;
    // Stage 0 ends, stage 1 (cycles 10-17) and stage 3 (cycles 28-35) pairs.
    tbl.push_back('{1, 0, 8, 0});   tbl.push_back('{8, 7, 15, 7});
    tbl.push_back('{10, 0, 4, 0});  tbl.push_back('{11, 1, 5, 2});
    tbl.push_back('{12, 2, 6, 4});  tbl.push_back('{13, 3, 7, 6});
    tbl.push_back('{14, 8, 12, 0}); tbl.push_back('{15, 9, 13, 2});
    tbl.push_back('{16, 10, 14, 4}); tbl.push_back('{17, 11, 15, 6});
    tbl.push_back('{28, 0, 1, 0});  tbl.push_back('{29, 2, 3, 0});
    tbl.push_back('{35, 14, 15, 0});

    p = 1;
    for (int t = 0; t < N; t++) begin
      wpow[t] = p;
      p = (p * 2) % P;
    end
    if1.start = 1'b0;
    if3.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // Basic run with starts at cycles 5, 20 and in FIN, then a back-to-back run.
    run_check(1'b0, 1'b1);
    run_check(1'b0, 1'b0);

    @(negedge clk);
    run_check(1'b1, 1'b0);

    // Golden: random data through the RAM/butterfly model, bit-reversed DFT.
    for (int rep = 0; rep < 2; rep++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      for (int n = 0; n < N; n++) init_mem[n] = $urandom % P;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      run_check(1'b0, 1'b0);
      for (int k = 0; k < N; k++) begin
        acc = 0;
        for (int n = 0; n < N; n++) acc = (acc + init_mem[n] * wpow[(n * k) % N]) % P;
        chk($sformatf("golden X[%0d]", k), mem[bitrev4(k)], acc);
      end
      $display("golden run %0d compared %0d bins, total=%0d bad=%0d", rep, N, total, bad);
    end

    // Reset mid-run at cycle 14.
    @(negedge clk);
    if1.start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if1.start = 1'b0;
    end
    chk("pre-reset busy", 32'(if1.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset c%0d wr_en", i), 32'(if1.wr_en), 0);
      chk($sformatf("post-reset c%0d busy", i),  32'(if1.busy), 0);
      chk($sformatf("post-reset c%0d rd_en", i), 32'(if1.rd_en), 0);
    end
    $display("reset mid-run checked, total=%0d bad=%0d", total, bad);
    run_check(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/but_stage_seq.md
Name: but_stage_seq

Overview:
- Sequencer for an in-place radix-2 DIF FFT built around one shared complex butterfly (but_complex) and a dual-port sample RAM.
- For each of N_LOG2 stages, it issues every butterfly pair's read addresses and the twiddle index, then issues delayed write-back addresses aligned with the RAM read latency.
- It drains the write pipeline between stages, then reports completion.
- It sits between the top-level FFT controller (start/done) and the RAM/twiddle ROM.

Parameters:
- N_LOG2, 4, log2 of FFT size N (N = 16 by default); legal range 2..10.
- RD_LAT, 1, RAM read latency in cycles from rd_en to valid read data; legal range 1..3.
- AW, N_LOG2, sample RAM address width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a full FFT; honoured only in IDLE.
- busy  out  1  high from the first RUN cycle through the last write cycle.
- done  out  1  one-cycle pulse, the cycle after the final write.
- stage  out  N_LOG2 bits (index width)  current stage index 0..N_LOG2-1.
- rd_en  out  1  RAM read strobe for both ports.
- rd_addr_a  out  AW  upper-leg address (feeds the *_0_8 inputs).
- rd_addr_b  out  AW  lower-leg address (feeds the *_8_16 inputs).
- tw_addr  out  N_LOG2-1 bits  twiddle ROM index, aligned with rd_en.
- wr_en  out  1  RAM write strobe; writes butterfly outputs p to addr_a and n to addr_b.
- wr_addr_a  out  AW  write address for out_p_r/out_p_i.
- wr_addr_b  out  AW  write address for out_n_r/out_n_i.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, rd_en and wr_en are 0; all addresses, stage and tw_addr are 0. Delay-line contents are cleared. Any in-flight FFT is abandoned and no write is issued after reset release.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE --start--> RUN. Stage s=0 and pair counter k=0 are loaded in the same edge.
  - RUN: rd_en=1 every cycle. k increments from 0 to N/2-1. At k=N/2-1, go to DRAIN.
  - DRAIN: rd_en=0 for exactly RD_LAT cycles, so the last write of the stage lands before the next stage reads. At the end of DRAIN: if s<N_LOG2-1, increment s, set k=0 and return to RUN; otherwise go to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Address generation, combinational from registered s and k, registered onto outputs:
  - span = N >> (s+1)
  - off = k & (span-1)
  - grp = k >> (N_LOG2-1-s)
  - rd_addr_a = grp*2*span + off
  - rd_addr_b = rd_addr_a + span
  - tw_addr = off << s
- Write path:
  - wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed by exactly RD_LAT cycles through a shift register.
  - The butterfly is combinational, so write data is valid in the same cycle as wr_en.
- start while busy, or in FIN: ignored, no queuing.
- stage holds its value through DRAIN and returns to 0 in IDLE.
- Per-stage cycle count is N/2 + RD_LAT. Total time from the start edge to the done pulse is N_LOG2*(N/2+RD_LAT)+1 cycles.
- No backpressure: RAM and butterfly are assumed always ready; this is a fixed property of the datapath.

Decomposition:
- Shared package fft_pkg:
  - FSM state enum (IDLE/RUN/DRAIN/FIN).
  - Functions for span/off/grp address math, reused by the future DIT sequencer and the testbench model.
- One natural sub-module: but_addr_dly, a parameterised RD_LAT-deep shift register for {en, addr_a, addr_b} with async active-low reset.

Test Plan (N_LOG2=4, RD_LAT=1 unless noted):
- Basic run: start pulse at cycle 0 -> rd_en high cycles 1-8; stage 0 pairs are (0,8),(1,9)…(7,15) with tw_addr 0..7; wr_en high cycles 2-9 with identical pairs; done pulse at cycle 37; busy high cycles 1-36.
- Stage address patterns:
  - Stage 1 -> pairs (0,4),(1,5),(2,6),(3,7),(8,12),(9,13),(10,14),(11,15); tw_addr 0,2,4,6,0,2,4,6.
  - Stage 3 -> pairs (0,1),(2,3)…(14,15); tw_addr all 0.
- Drain gap: RD_LAT=3 -> 3 idle read cycles between stages; last wr_en of stage s precedes first rd_en of stage s+1; done at cycle 4*(8+3)+1 = 45.
- start during busy at cycle 5 and cycle 20 -> ignored; exactly one done pulse at cycle 37; second start at cycle 38 -> new run with done at cycle 75.
- Reset mid-run: rst_n low at cycle 14 -> all outputs 0 immediately (asynchronously); no wr_en after release; a subsequent start runs a clean full sequence.
- Golden check: random 16-point complex input through RAM + but_complex + ROM model -> bit-exact match to the reference DIF model output in bit-reversed order.
